// File: rtl/bin_vs_transfer_pkg.sv
// Shared bin-manager definitions: variable-state word layout and the
// BRAM transfer sequencer states.
package bin_mgr_pkg;

  localparam int unsigned VALUE_W = 3;
  localparam int unsigned LVL_W   = 16;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [LVL_W-1:0]   lvl;
  } vs_word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    STORE,
    FIN
  } xfer_state_t;

endpackage

// File: rtl/bin_vs_transfer_if.sv
// Port-A BRAM / bin datapath bundle for the variable-state transfer engine.
// master = transfer engine, slave = surrounding bin manager + BRAM.
interface bin_vs_transfer_if #(
  parameter int unsigned DATA_WIDTH = 19,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned VALUE_W    = 3,
  parameter int unsigned LVL_W      = 16,
  parameter int unsigned IDX_W      = 4
) ();

  logic                  start_load;
  logic                  start_store;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [IDX_W-1:0]      len;
  logic                  busy;
  logic                  done;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  vs_valid;
  logic [IDX_W-1:0]      vs_index;
  logic [VALUE_W-1:0]    vs_value;
  logic [LVL_W-1:0]      vs_lvl;
  logic [IDX_W-1:0]      st_index;
  logic [VALUE_W-1:0]    st_value;
  logic [LVL_W-1:0]      st_lvl;

  modport master (
    input  start_load, start_store, base_addr, len, douta, st_value, st_lvl,
    output busy, done, wea, addra, dina, vs_valid, vs_index, vs_value, vs_lvl,
           st_index
  );

  modport slave (
    output start_load, start_store, base_addr, len, douta, st_value, st_lvl,
    input  busy, done, wea, addra, dina, vs_valid, vs_index, vs_value, vs_lvl,
           st_index
  );

endinterface

// File: rtl/bin_vs_transfer.sv
// Port-A initiator moving one bin's {value,lvl} words between BRAM and the
// bin datapath as a LOAD (BRAM -> bin) or STORE (bin -> BRAM) burst.
module bin_vs_transfer #(
  parameter int unsigned DATA_WIDTH = 19,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned VALUE_W    = 3,
  parameter int unsigned LVL_W      = 16,
  parameter int unsigned NUM_VARS   = 8,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bin_vs_transfer_if.master    bus
);

  import bin_mgr_pkg::*;

  xfer_state_t           state_q;
  logic [IDX_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      n_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wea_q;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic [DATA_WIDTH-1:0] dina_q;
  logic                  vs_valid_q;
  logic [IDX_W-1:0]      vs_index_q;
  logic [IDX_W-1:0]      st_index_q;

  logic [IDX_W-1:0]      n_clamp_d;
  logic [ADDR_WIDTH-1:0] first_addr_d;
  logic [DATA_WIDTH-1:0] word_d;
  logic [IDX_W-1:0]      cnt_inc_d;

  always_comb begin
    n_clamp_d    = (bus.len > IDX_W'(NUM_VARS)) ? IDX_W'(NUM_VARS) : bus.len;
    first_addr_d = bus.base_addr + ADDR_WIDTH'(1);
    word_d       = DATA_WIDTH'({bus.st_value, bus.st_lvl});
    cnt_inc_d    = cnt_q + IDX_W'(1);
  end

  // cnt_q: LOAD = index of the address currently on addra;
  //        STORE = number of words already captured into dina.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      vs_valid_q <= 1'b0;
      vs_index_q <= '0;
      st_index_q <= '0;
    end else begin
      done_q     <= 1'b0;
      wea_q      <= 1'b0;
      vs_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q     <= 1'b0;
          vs_index_q <= '0;
          st_index_q <= '0;
          if (bus.start_load || bus.start_store) begin
            busy_q <= 1'b1;
            n_q    <= n_clamp_d;
            cnt_q  <= '0;
            if (n_clamp_d == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else if (bus.start_load) begin
              state_q <= LOAD;
              addra_q <= first_addr_d;
            end else begin
              // Word 0 is presented by the bin during the start cycle itself.
              state_q    <= STORE;
              wea_q      <= 1'b1;
              addra_q    <= first_addr_d;
              dina_q     <= word_d;
              cnt_q      <= IDX_W'(1);
              st_index_q <= (n_clamp_d == IDX_W'(1)) ? '0 : IDX_W'(1);
            end
          end
        end

        LOAD: begin
          vs_valid_q <= 1'b1;
          vs_index_q <= cnt_q;
          if (cnt_q == n_q - IDX_W'(1)) begin
            state_q <= DRAIN;
            done_q  <= 1'b1;
          end else begin
            addra_q <= addra_q + ADDR_WIDTH'(1);
            cnt_q   <= cnt_inc_d;
          end
        end

        DRAIN: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          vs_index_q <= '0;
        end

        STORE: begin
          if (cnt_q == n_q) begin
            state_q    <= FIN;
            done_q     <= 1'b1;
            st_index_q <= '0;
          end else begin
            wea_q      <= 1'b1;
            addra_q    <= addra_q + ADDR_WIDTH'(1);
            dina_q     <= word_d;
            cnt_q      <= cnt_inc_d;
            st_index_q <= (cnt_inc_d == n_q) ? '0 : cnt_inc_d;
          end
        end

        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wea      = wea_q;
  assign bus.addra    = addra_q;
  assign bus.dina     = dina_q;
  assign bus.vs_valid = vs_valid_q;
  assign bus.vs_index = vs_index_q;
  assign bus.st_index = st_index_q;
  assign bus.vs_value = bus.douta[DATA_WIDTH-1 -: VALUE_W];
  assign bus.vs_lvl   = bus.douta[LVL_W-1:0];

endmodule

// File: tb/tb_bin_vs_transfer.sv
// Table-driven bench for bin_vs_transfer with an inline 1-cycle-latency BRAM
// model; every word starts at init_word(addr) so untouched cells are known.
module tb_bin_vs_transfer;
  import bin_mgr_pkg::*;

  logic clk;
  logic rst;

  bin_vs_transfer_if #(
    .DATA_WIDTH(19), .ADDR_WIDTH(10), .VALUE_W(3), .LVL_W(16), .IDX_W(4)
  ) bus ();

  bin_vs_transfer #(
    .DATA_WIDTH(19), .ADDR_WIDTH(10), .VALUE_W(3), .LVL_W(16),
    .NUM_VARS(8), .IDX_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] init_word(input logic [9:0] a);
    vs_word_t w;
    w.value = a[2:0];
    w.lvl   = {6'd0, a} - 16'h003C;
    return w;
  endfunction

  // BRAM port A: read-first, registered output; sole writer of mem.
  logic [18:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(10'(i));
    forever begin
      @(posedge clk);
      bus.douta <= mem[bus.addra];
      if (bus.wea) mem[bus.addra] = bus.dina;
    end
  end

  logic [15:0] lvl_base;
  assign bus.st_value = 3'b010;
  assign bus.st_lvl   = lvl_base + {12'd0, bus.st_index};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          store;
    bit          both;
    logic [9:0]  base;
    logic [3:0]  len;
    int unsigned n;
    logic [9:0]  a_first;
    logic [15:0] lvl0;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic run_burst(input vec_t v, input int row);
    bit          is_load;
    logic [9:0]  a;
    logic [18:0] w;
    is_load         = !v.store || v.both;
    bus.base_addr   = v.base;
    bus.len         = v.len;
    lvl_base        = v.lvl0;
    bus.start_load  = is_load;
    bus.start_store = v.store || v.both;
    @(posedge clk); #1;
    bus.start_load  = 1'b0;
    bus.start_store = 1'b0;
    for (int c = 1; c <= int'(v.n) + 1; c++) begin
      chk($sformatf("r%0d c%0d busy", row, c), 32'(bus.busy), 32'd1);
      chk($sformatf("r%0d c%0d done", row, c), 32'(bus.done), 32'(c == int'(v.n) + 1));
      if (c <= int'(v.n)) begin
        a = v.a_first + 10'(c - 1);
        chk($sformatf("r%0d c%0d addra", row, c), 32'(bus.addra), 32'(a));
      end
      if (is_load) begin
        chk($sformatf("r%0d c%0d wea", row, c), 32'(bus.wea), 32'd0);
        chk($sformatf("r%0d c%0d st_index", row, c), 32'(bus.st_index), 32'd0);
        chk($sformatf("r%0d c%0d vs_valid", row, c), 32'(bus.vs_valid), 32'(c >= 2));
        if (c >= 2) begin
          w = init_word(v.a_first + 10'(c - 2));
          chk($sformatf("r%0d c%0d vs_index", row, c), 32'(bus.vs_index), 32'(c - 2));
          chk($sformatf("r%0d c%0d vs_value", row, c), 32'(bus.vs_value), 32'(w[18:16]));
          chk($sformatf("r%0d c%0d vs_lvl", row, c), 32'(bus.vs_lvl), 32'(w[15:0]));
        end
      end else begin
        chk($sformatf("r%0d c%0d wea", row, c), 32'(bus.wea), 32'(c <= int'(v.n)));
        chk($sformatf("r%0d c%0d vs_valid", row, c), 32'(bus.vs_valid), 32'd0);
        chk($sformatf("r%0d c%0d st_index", row, c), 32'(bus.st_index),
            (c < int'(v.n)) ? 32'(c) : 32'd0);
        if (c <= int'(v.n))
          chk($sformatf("r%0d c%0d dina", row, c), 32'(bus.dina),
              32'({3'b010, v.lvl0 + 16'(c - 1)}));
      end
      @(posedge clk); #1;
    end
    chk($sformatf("r%0d idle busy", row), 32'(bus.busy), 32'd0);
    chk($sformatf("r%0d idle done", row), 32'(bus.done), 32'd0);
    chk($sformatf("r%0d idle wea", row), 32'(bus.wea), 32'd0);
    chk($sformatf("r%0d idle vs_valid", row), 32'(bus.vs_valid), 32'd0);
    if (!is_load) begin
      for (int k = 0; k < int'(v.n); k++) begin
        a = v.a_first + 10'(k);
        chk($sformatf("r%0d mem[%0h]", row, a), 32'(mem[a]), 32'({3'b010, v.lvl0 + 16'(k)}));
      end
      a = v.base;
      chk($sformatf("r%0d mem below", row), 32'(mem[a]), 32'(init_word(a)));
      a = v.base + 10'(v.n + 1);
      chk($sformatf("r%0d mem above", row), 32'(mem[a]), 32'(init_word(a)));
    end
  endtask

  initial begin
    int dones;
    int vals;
    bit wea_seen;
    logic [9:0] a;

    tbl[0] = '{store:1'b0, both:1'b0, base:10'h040, len:4'd4,  n:4, a_first:10'h041, lvl0:16'h0000};
    tbl[1] = '{store:1'b1, both:1'b0, base:10'h100, len:4'd3,  n:3, a_first:10'h101, lvl0:16'd7};
    tbl[2] = '{store:1'b1, both:1'b0, base:10'h180, len:4'd0,  n:0, a_first:10'h181, lvl0:16'h0000};
    tbl[3] = '{store:1'b0, both:1'b0, base:10'h200, len:4'd15, n:8, a_first:10'h201, lvl0:16'h0000};
    tbl[4] = '{store:1'b0, both:1'b0, base:10'h3FE, len:4'd4,  n:4, a_first:10'h3FF, lvl0:16'h0000};
    tbl[5] = '{store:1'b0, both:1'b1, base:10'h060, len:4'd2,  n:2, a_first:10'h061, lvl0:16'h0000};
    tbl[6] = '{store:1'b1, both:1'b0, base:10'h280, len:4'd15, n:8, a_first:10'h281, lvl0:16'h0100};
    tbl[7] = '{store:1'b1, both:1'b0, base:10'h300, len:4'd1,  n:1, a_first:10'h301, lvl0:16'hFFFF};
    tbl[8] = '{store:1'b0, both:1'b0, base:10'h0C0, len:4'd1,  n:1, a_first:10'h0C1, lvl0:16'h0000};
    tbl[9] = '{store:1'b0, both:1'b0, base:10'h0E0, len:4'd0,  n:0, a_first:10'h0E1, lvl0:16'h0000};

    rst = 1'b1;
    bus.start_load  = 1'b0;
    bus.start_store = 1'b0;
    bus.base_addr   = '0;
    bus.len         = '0;
    lvl_base        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst wea", 32'(bus.wea), 32'd0);
    chk("rst vs_valid", 32'(bus.vs_valid), 32'd0);
    chk("rst addra", 32'(bus.addra), 32'd0);
    chk("rst dina", 32'(bus.dina), 32'd0);
    chk("rst vs_index", 32'(bus.vs_index), 32'd0);
    chk("rst st_index", 32'(bus.st_index), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Rows run back to back: each starts in the idle cycle right after done.
    for (int r = 0; r < NV; r++) run_burst(tbl[r], r);

    // LOAD with a STORE request arriving while busy: only the LOAD happens.
    bus.base_addr  = 10'h0A0;
    bus.len        = 4'd3;
    bus.start_load = 1'b1;
    @(posedge clk); #1;
    bus.start_load  = 1'b0;
    bus.start_store = 1'b1;
    dones = 0; vals = 0; wea_seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) bus.start_store = 1'b0;
      if (bus.wea) wea_seen = 1'b1;
      if (bus.done) dones++;
      if (bus.vs_valid) vals++;
      @(posedge clk); #1;
    end
    chk("busy-ign wea_seen", 32'(wea_seen), 32'd0);
    chk("busy-ign dones", 32'(dones), 32'd1);
    chk("busy-ign vs_valid count", 32'(vals), 32'd3);
    chk("busy-ign final busy", 32'(bus.busy), 32'd0);

    // Reset during a STORE after two words have been written.
    bus.base_addr   = 10'h380;
    bus.len         = 4'd3;
    lvl_base        = 16'h00AA;
    bus.start_store = 1'b1;
    @(posedge clk); #1;
    bus.start_store = 1'b0;
    chk("rstmid c1 wea", 32'(bus.wea), 32'd1);
    @(posedge clk); #1;
    chk("rstmid c2 wea", 32'(bus.wea), 32'd1);
    @(posedge clk); #1;
    chk("rstmid c3 wea pre", 32'(bus.wea), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid wea async", 32'(bus.wea), 32'd0);
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    chk("rstmid done", 32'(bus.done), 32'd0);
    chk("rstmid st_index", 32'(bus.st_index), 32'd0);
    #1;
    rst = 1'b0;
    dones = 0; wea_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
      if (bus.wea || bus.busy) wea_seen = 1'b1;
    end
    chk("rstmid later done", 32'(dones), 32'd0);
    chk("rstmid later wea/busy", 32'(wea_seen), 32'd0);
    a = 10'h381;
    chk("rstmid mem381", 32'(mem[a]), 32'({3'b010, 16'h00AA}));
    a = 10'h382;
    chk("rstmid mem382", 32'(mem[a]), 32'({3'b010, 16'h00AB}));
    a = 10'h383;
    chk("rstmid mem383", 32'(mem[a]), 32'(init_word(a)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
